bind_xor_checker: RTL and testbench

- Sequential checker module, attached with `bind` to a host cell that drives `c` from inputs `a` and `b`.
- The host cell's contract is `c = DOIT ? a^b : 0`, where the result may arrive LAT cycles after the inputs.
- The checker samples `a`, `b` and `c` each clock, compares `c` with the expected value, counts checks and mismatches, and captures the first failing vector.
- It sits on the observing side of the parity-cell interface and reports through sticky status outputs. `clr` re-arms it.

---
 rtl/bind_xor_checker.sv | 158 +++++++++++++++
 tb/tb_bind_xor_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bind_xor_checker.sv
// ============================================================================
// Module   : bind_xor_checker
// Brief    : Bound observer for a parity cell (c = DOIT ? a^b : 0, LAT late).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bind_xor_checker #(
  parameter int DOIT         = 1,
  parameter int LAT          = 0,
  parameter int WARMUP       = 2,
  parameter int CNT_W        = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             sample_en,
  input  logic             clr,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic             fail_a,
  output logic             fail_b,
  output logic             fail_c
);

  localparam int EFF_WU  = (WARMUP > LAT) ? WARMUP : LAT;
  localparam int WU_LAST = (EFF_WU > 1) ? EFF_WU - 1 : 0;
  localparam int WU_W    = (WU_LAST > 0) ? $clog2(WU_LAST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_CHECK = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [WU_W-1:0] r_wu, w_wu_nxt;
  logic            w_a_d, w_b_d, w_exp, w_mis, w_do_chk;

  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt, r_chk_cnt;
  logic             r_fail_a, r_fail_b, r_fail_c;

  // The delay line free-runs so expected values stay aligned with the host pipe.
  if (LAT == 0) begin : g_lat0
    assign w_a_d = a;
    assign w_b_d = b;
  end else begin : g_latn
    logic [LAT-1:0] r_a_dl, r_b_dl;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a_dl <= '0;
        r_b_dl <= '0;
      end else begin
        r_a_dl <= (r_a_dl << 1) | LAT'(a);
        r_b_dl <= (r_b_dl << 1) | LAT'(b);
      end
    end
    assign w_a_d = r_a_dl[LAT-1];
    assign w_b_d = r_b_dl[LAT-1];
  end

  assign w_exp = (DOIT != 0) ? (w_a_d ^ w_b_d) : 1'b0;
  assign w_mis = c ^ w_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wu    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wu    <= w_wu_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wu_nxt    = r_wu;
    w_do_chk    = 1'b0;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_wu_nxt    = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sample_en) begin
            w_state_nxt = S_ARM;
            w_wu_nxt    = '0;
          end
        end
        S_ARM: begin
          if (!sample_en)                   w_state_nxt = S_IDLE;
          else if (r_wu == WU_W'(WU_LAST))  w_state_nxt = S_CHECK;
          else                              w_wu_nxt    = r_wu + WU_W'(1);
        end
        S_CHECK: begin
          if (!sample_en) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_do_chk = 1'b1;
            if (w_mis && (STOP_ON_FAIL != 0)) w_state_nxt = S_HALT;
          end
        end
        S_HALT:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // clr takes priority, so a mismatch on the clearing edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_chk_cnt <= '0;
      r_fail_a  <= 1'b0;
      r_fail_b  <= 1'b0;
      r_fail_c  <= 1'b0;
    end else if (clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_chk_cnt <= '0;
      r_fail_a  <= 1'b0;
      r_fail_b  <= 1'b0;
      r_fail_c  <= 1'b0;
    end else if (w_do_chk) begin
      if (r_chk_cnt != CNT_MAX) r_chk_cnt <= r_chk_cnt + CNT_ONE;
      if (w_mis) begin
        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_ONE;
        if (!r_err) begin
          r_err    <= 1'b1;
          r_fail_a <= w_a_d;
          r_fail_b <= w_b_d;
          r_fail_c <= c;
        end
      end
    end
  end

  assign state   = r_state;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign chk_cnt = r_chk_cnt;
  assign fail_a  = r_fail_a;
  assign fail_b  = r_fail_b;
  assign fail_c  = r_fail_c;

endmodule

`default_nettype wire

// File: tb/tb_bind_xor_checker.sv
// ============================================================================
// Module   : tb_bind_xor_checker
// Brief    : Scoreboarded bench for bind_xor_checker across three configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bind_xor_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, sample_en = 1'b0, clr = 1'b0;
  logic c_m = 1'b0, c_z = 1'b0, c_h = 1'b0;

  logic [1:0] st_m, st_z, st_h;
  logic       err_m, err_z, err_h;
  logic [3:0] ec_m, chk_m;
  logic [7:0] ec_z, chk_z, ec_h, chk_h;
  logic       fa_m, fb_m, fc_m, fa_z, fb_z, fc_z, fa_h, fb_h, fc_h;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  // Main: LAT=1, narrow counters. Zero: DOIT=0, no warmup. Halt: stop on fail.
  bind_xor_checker #(.DOIT(1), .LAT(1), .WARMUP(2), .CNT_W(4), .STOP_ON_FAIL(0)) u_main (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c_m), .sample_en(sample_en), .clr(clr),
    .state(st_m), .err(err_m), .err_cnt(ec_m), .chk_cnt(chk_m),
    .fail_a(fa_m), .fail_b(fb_m), .fail_c(fc_m));

  bind_xor_checker #(.DOIT(0), .LAT(0), .WARMUP(0), .CNT_W(8), .STOP_ON_FAIL(0)) u_zero (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c_z), .sample_en(sample_en), .clr(clr),
    .state(st_z), .err(err_z), .err_cnt(ec_z), .chk_cnt(chk_z),
    .fail_a(fa_z), .fail_b(fb_z), .fail_c(fc_z));

  bind_xor_checker #(.DOIT(1), .LAT(0), .WARMUP(2), .CNT_W(8), .STOP_ON_FAIL(1)) u_halt (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c_h), .sample_en(sample_en), .clr(clr),
    .state(st_h), .err(err_h), .err_cnt(ec_h), .chk_cnt(chk_h),
    .fail_a(fa_h), .fail_b(fb_h), .fail_c(fc_h));

  typedef struct {
    int st, wu, err, ec, chk, fa, fb, fc;
    bit [3:0] ha, hb;
  } mdl_t;

  mdl_t m_m, m_z, m_h;
  logic [21:0] q_m[$], q_z[$], q_h[$];
  bit host_pa = 1'b0, host_pb = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic mdl_t mstep(mdl_t m, int doit, int lat, int ew, int cmax, int stop,
                                 bit se, bit cl, bit ia, bit ib, bit ic);
    mdl_t n = m;
    bit ad, bd, ex;
    if (lat == 0) begin
      ad = ia; bd = ib;
    end else begin
      ad = m.ha[lat-1]; bd = m.hb[lat-1];
    end
    ex = (doit != 0) ? (ad ^ bd) : 1'b0;
    n.ha = {m.ha[2:0], ia};
    n.hb = {m.hb[2:0], ib};
    if (cl) begin
      n.st = 0; n.wu = 0; n.err = 0; n.ec = 0; n.chk = 0; n.fa = 0; n.fb = 0; n.fc = 0;
    end else begin
      case (m.st)
        0: if (se) begin n.st = 1; n.wu = 0; end
        1: begin
          if (!se) n.st = 0;
          else if (m.wu >= ew - 1) n.st = 2;
          else n.wu = m.wu + 1;
        end
        2: begin
          if (!se) n.st = 0;
          else begin
            if (m.chk < cmax) n.chk = m.chk + 1;
            if (ic != ex) begin
              if (m.ec < cmax) n.ec = m.ec + 1;
              if (m.err == 0) begin
                n.err = 1; n.fa = int'(ad); n.fb = int'(bd); n.fc = int'(ic);
              end
              if (stop != 0) n.st = 3;
            end
          end
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [21:0] msnap(mdl_t m);
    logic [31:0] st, er, ec, ck, fa, fb, fc;
    st = m.st; er = m.err; ec = m.ec; ck = m.chk; fa = m.fa; fb = m.fb; fc = m.fc;
    return {st[1:0], er[0], ec[7:0], ck[7:0], fa[0], fb[0], fc[0]};
  endfunction

  function automatic logic [21:0] dsnap(logic [1:0] st, logic er, logic [7:0] ec,
                                        logic [7:0] ck, logic fa, logic fb, logic fc);
    return {st, er, ec, ck, fa, fb, fc};
  endfunction

  task automatic tick(input bit ia, input bit ib, input bit se, input bit cl,
                      input bit fm, input bit fz, input bit fh);
    a = ia; b = ib; sample_en = se; clr = cl;
    c_m = host_pa ^ host_pb ^ fm;
    c_z = fz;
    c_h = ia ^ ib ^ fh;
    m_m = mstep(m_m, 1, 1, 2, 15, 0, se, cl, ia, ib, c_m);
    m_z = mstep(m_z, 0, 0, 0, 255, 0, se, cl, ia, ib, c_z);
    m_h = mstep(m_h, 1, 0, 2, 255, 1, se, cl, ia, ib, c_h);
    q_m.push_back(msnap(m_m));
    q_z.push_back(msnap(m_z));
    q_h.push_back(msnap(m_h));
    host_pa = ia; host_pb = ib;
    @(posedge clk);
    #1;
    check("snap_main", 32'(dsnap(st_m, err_m, {4'b0, ec_m}, {4'b0, chk_m}, fa_m, fb_m, fc_m)),
          32'(q_m.pop_front()));
    check("snap_zero", 32'(dsnap(st_z, err_z, ec_z, chk_z, fa_z, fb_z, fc_z)),
          32'(q_z.pop_front()));
    check("snap_halt", 32'(dsnap(st_h, err_h, ec_h, chk_h, fa_h, fb_h, fc_h)),
          32'(q_h.pop_front()));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_main"}, 32'(dsnap(st_m, err_m, {4'b0, ec_m}, {4'b0, chk_m}, fa_m, fb_m, fc_m)), 0);
    check({tag, "_zero"}, 32'(dsnap(st_z, err_z, ec_z, chk_z, fa_z, fb_z, fc_z)), 0);
    check({tag, "_halt"}, 32'(dsnap(st_h, err_h, ec_h, chk_h, fa_h, fb_h, fc_h)), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    check_all_zero("async_rst");
    m_m = '{default: 0}; m_z = '{default: 0}; m_h = '{default: 0};
    host_pa = 1'b0; host_pb = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_m = '{default: 0}; m_z = '{default: 0}; m_h = '{default: 0};
    #3;
    check_all_zero("reset");
    #10 rst_n = 1'b1;

    // Ideal host, walking a/b.
    for (int i = 0; i < 11; i++) begin
      logic [1:0] v;
      v = 2'(i);
      tick(v[1], v[0], 1, 0, 0, 0, 0);
      if (i == 0) check("halt_st_e1", 32'(st_h), 1);
      if (i == 1) check("halt_st_e2", 32'(st_h), 1);
      if (i == 2) check("halt_st_e3", 32'(st_h), 2);
    end
    check("halt_chk_ideal", 32'(chk_h), 8);
    check("halt_err_ideal", 32'(err_h), 0);
    check("halt_ec_ideal", 32'(ec_h), 0);
    check("main_chk_ideal", 32'(chk_m), 8);
    check("main_ec_ideal", 32'(ec_m), 0);

    // Fault on the delayed (1,0) vector, then a second fault.
    tick(1, 0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 1, 0, 0);
    check("main_err_f1", 32'(err_m), 1);
    check("main_ec_f1", 32'(ec_m), 1);
    check("main_fail_f1", 32'({fa_m, fb_m, fc_m}), 32'b100);
    tick(0, 1, 1, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 1, 0, 0);
    check("main_ec_f2", 32'(ec_m), 2);
    check("main_fail_f2", 32'({fa_m, fb_m, fc_m}), 32'b100);

    // Constant-zero contract.
    for (int i = 0; i < 20; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0, 0, 0);
    check("zero_ec_clean", 32'(ec_z), 0);
    for (int i = 0; i < 3; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0, 1, 0);
    check("zero_ec_bad", 32'(ec_z), 3);

    // Re-arm, saturate main, halt the stop-on-fail instance.
    tick(0, 0, 1, 1, 0, 0, 0);
    check_all_zero("clr");
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 1, 0, (i == 1));
      if (i == 1) check("halt_st_fault", 32'(st_h), 3);
    end
    check("main_ec_sat", 32'(ec_m), 15);
    check("main_chk_sat", 32'(chk_m), 15);
    check("halt_st_hold", 32'(st_h), 3);
    check("halt_ec_hold", 32'(ec_h), 1);
    check("halt_chk_hold", 32'(chk_h), 2);

    // clr on a mismatching edge.
    tick(1, 0, 1, 1, 1, 0, 0);
    check("clr_mis_err", 32'(err_m), 0);
    check("clr_mis_ec", 32'(ec_m), 0);
    check("clr_mis_st", 32'(st_m), 0);

    // sample_en dropout.
    for (int i = 0; i < 6; i++) tick(i[0], i[1], 1, 0, 0, 0, 0);
    check("drop_pre_chk", 32'(chk_m), 3);
    tick(1, 1, 0, 0, 0, 0, 0);
    check("drop_st", 32'(st_m), 0);
    check("drop_chk_kept", 32'(chk_m), 3);
    tick(0, 1, 1, 0, 0, 0, 0);
    check("drop_rearm", 32'(st_m), 1);
    tick(1, 0, 1, 0, 0, 0, 0);
    tick(1, 1, 1, 0, 0, 0, 0);
    check("drop_check", 32'(st_m), 2);
    check("drop_chk_gap", 32'(chk_m), 3);
    tick(0, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 0, 0);
    check("drop_chk_post", 32'(chk_m), 5);

    // Asynchronous reset mid-CHECK.
    pulse_reset();
    for (int i = 0; i < 4; i++) tick(i[0], 1, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
